// File: rtl/alu_exec_stage_if.sv
// Valid/ready bundle linking the ALU decoder, the execute stage and the writeback stage.
interface alu_exec_stage_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        alu_opcode;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic [3:0]        flags;

  modport master (
    output in_valid, alu_opcode, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, alu_opcode, op_a, op_b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_exec_stage.sv
// ALU execute stage: one op in flight, registered result and {Z,N,C,V} flags.
// Define ALU_BARREL_SHIFT_EN for single-cycle shifts; otherwise shifts step one bit per cycle.
module alu_exec_stage #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_exec_stage_if.slave io_alu
);
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_NOT = 3'b101, OP_LSL = 3'b110, OP_LSR = 3'b111
  } opcode_t;

  localparam int MSB = DATA_W - 1;

  opcode_t            w_op;
  logic [DATA_W-1:0]  w_a;
  logic [DATA_W-1:0]  w_b;
  logic [SHAMT_W-1:0] w_shamt;
  logic [DATA_W-1:0]  w_res;
  logic               w_c;
  logic               w_v;
  logic [3:0]         w_flags;
  logic               w_out_free;
  logic               w_accept;

  logic               r_out_valid;
  logic [DATA_W-1:0]  r_result;
  logic [3:0]         r_flags;

  assign w_op       = opcode_t'(io_alu.alu_opcode);
  assign w_a        = io_alu.op_a;
  assign w_b        = io_alu.op_b;
  assign w_shamt    = io_alu.op_b[SHAMT_W-1:0];
  assign w_out_free = !r_out_valid || io_alu.out_ready;
  assign w_accept   = io_alu.in_valid && io_alu.in_ready;

  always_comb begin
    // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OP_ADD: begin
        {w_c, w_res} = {1'b0, w_a} + {1'b0, w_b};
        w_v = (w_a[MSB] == w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
      end
      OP_SUB: begin
        w_res = w_a - w_b;
        w_c   = (w_a >= w_b);
        w_v   = (w_a[MSB] != w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
      end
      OP_AND: w_res = w_a & w_b;
      OP_OR:  w_res = w_a | w_b;
      OP_XOR: w_res = w_a ^ w_b;
      OP_NOT: w_res = ~w_a;
`ifdef ALU_BARREL_SHIFT_EN
      // The extra bit beyond the data catches the last bit shifted out.
      OP_LSL: {w_c, w_res} = {1'b0, w_a} << w_shamt;
      OP_LSR: {w_res, w_c} = {w_a, 1'b0} >> w_shamt;
`endif
      default: ;
    endcase
  end

  assign w_flags = {(w_res == '0), w_res[MSB], w_c, w_v};

`ifdef ALU_BARREL_SHIFT_EN
  assign io_alu.in_ready = rst_n && w_out_free;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_flags     <= w_flags;
    end else if (io_alu.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
`else
  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [DATA_W-1:0]  r_work;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_c_acc;
  logic               r_is_lsl;
  logic               w_is_shift;
  logic               w_shift_load;
  logic               w_shift_step;
  logic               w_shift_done;

  assign w_is_shift      = (w_op == OP_LSL) || (w_op == OP_LSR);
  assign io_alu.in_ready = rst_n && (r_state == S_IDLE) && w_out_free;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_load = 1'b0;
    w_shift_step = 1'b0;
    w_shift_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_shift) begin
          w_shift_load = 1'b1;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt != '0) begin
          w_shift_step = 1'b1;
        end else if (w_out_free) begin
          w_shift_done = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_work      <= '0;
      r_cnt       <= '0;
      r_c_acc     <= 1'b0;
      r_is_lsl    <= 1'b0;
    end else begin
      if (w_accept && !w_is_shift) begin
        r_out_valid <= 1'b1;
        r_result    <= w_res;
        r_flags     <= w_flags;
      end else if (w_shift_done) begin
        r_out_valid <= 1'b1;
        r_result    <= r_work;
        r_flags     <= {(r_work == '0), r_work[MSB], r_c_acc, 1'b0};
      end else if (io_alu.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_shift_load) begin
        r_work   <= w_a;
        r_cnt    <= w_shamt;
        r_c_acc  <= 1'b0;
        r_is_lsl <= (w_op == OP_LSL);
      end else if (w_shift_step) begin
        if (r_is_lsl) begin
          r_work  <= {r_work[MSB-1:0], 1'b0};
          r_c_acc <= r_work[MSB];
        end else begin
          r_work  <= {1'b0, r_work[MSB:1]};
          r_c_acc <= r_work[0];
        end
        r_cnt <= r_cnt - SHAMT_W'(1);
      end
    end
  end
`endif

  assign io_alu.out_valid = r_out_valid;
  assign io_alu.result    = r_result;
  assign io_alu.flags     = r_flags;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: arithmetic/logic/shift vectors, backpressure, mid-shift reset.
module tb_alu_exec_stage;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         XOR_ = 3'b100, NOT_ = 3'b101, LSL = 3'b110, LSR = 3'b111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  alu_exec_stage_if #(.DATA_W(8)) bus ();

  alu_exec_stage #(.DATA_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_alu (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges from the accept edge until out_valid is first seen.
  function automatic int shlat(input int s);
`ifdef ALU_BARREL_SHIFT_EN
    return 0;
`else
    return s + 1;
`endif
  endfunction

  task automatic wait_valid(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  // Issue one op with out_ready low, measure latency, check result and flags, then retire it.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input int exp_lat, input logic [7:0] exp_res,
                       input logic [3:0] exp_flg);
    int n;
    bus.alu_opcode = op;
    bus.op_a       = a;
    bus.op_b       = b;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b0;
    #1;
    check({tag, "_in_ready"}, bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    wait_valid(n);
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_flags"}, bus.flags, exp_flg);
    bus.out_ready = 1'b1;
    step();
    check({tag, "_retired"}, bus.out_valid, 0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int n;
    bus.in_valid   = 1'b0;
    bus.alu_opcode = ADD;
    bus.op_a       = '0;
    bus.op_b       = '0;
    bus.out_ready  = 1'b0;

    // Reset state
    step();
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_flags", bus.flags, 0);
    check("rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", bus.in_ready, 1);

    // Arithmetic and logic vectors ({Z,N,C,V})
    do_op("add_ovf",  ADD,  8'h7F, 8'h01, 0, 8'h80, 4'b0101);
    do_op("add_wrap", ADD,  8'hFF, 8'h01, 0, 8'h00, 4'b1010);
    do_op("sub_neg",  SUB,  8'h05, 8'h07, 0, 8'hFE, 4'b0100);
    do_op("sub_ovf",  SUB,  8'h80, 8'h01, 0, 8'h7F, 4'b0011);
    do_op("and_zero", AND_, 8'hF0, 8'h0F, 0, 8'h00, 4'b1000);
    do_op("or",       OR_,  8'hA0, 8'h05, 0, 8'hA5, 4'b0100);
    do_op("xor_zero", XOR_, 8'h5A, 8'h5A, 0, 8'h00, 4'b1000);
    do_op("not",      NOT_, 8'h0F, 8'hFF, 0, 8'hF0, 4'b0100);

    // Shifts
    do_op("lsr_1",    LSR,  8'h81, 8'h01, shlat(1), 8'h40, 4'b0010);
    do_op("lsl_0",    LSL,  8'h93, 8'h08, shlat(0), 8'h93, 4'b0100);
    do_op("lsl_7",    LSL,  8'hFF, 8'h07, shlat(7), 8'h80, 4'b0110);
    do_op("lsr_7",    LSR,  8'h80, 8'h07, shlat(7), 8'h01, 4'b0000);

    // LSL by 3 with the consumer always ready: in_ready must drop while shifting
    bus.alu_opcode = LSL;
    bus.op_a       = 8'h81;
    bus.op_b       = 8'h03;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b1;
    #1;
    check("lsl3_in_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
`ifdef ALU_BARREL_SHIFT_EN
    check("lsl3_busy_in_ready", bus.in_ready, 1);
`else
    check("lsl3_busy_in_ready", bus.in_ready, 0);
`endif
    wait_valid(n);
    check("lsl3_latency", n, shlat(3));
    check("lsl3_result", bus.result, 8'h08);
    check("lsl3_flags", bus.flags, 4'b0000);
    step();
    check("lsl3_retired", bus.out_valid, 0);

    // Backpressure: one result pending, another op offered but refused
    bus.out_ready  = 1'b0;
    bus.alu_opcode = ADD;
    bus.op_a       = 8'h10;
    bus.op_b       = 8'h20;
    bus.in_valid   = 1'b1;
    step();
    bus.op_a = 8'h01;
    bus.op_b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_result", bus.result, 8'h30);
      check("bp_flags", bus.flags, 4'b0000);
      step();
    end

    // Retire and accept on the same edge, then 8 back-to-back ADDs
    bus.out_ready = 1'b1;
    #1;
    check("rel_in_ready", bus.in_ready, 1);
    step();
    check("rel_out_valid", bus.out_valid, 1);
    check("rel_result", bus.result, 8'h02);
    bus.op_b = 8'h10;
    for (int i = 0; i < 8; i++) begin
      bus.op_a = 8'(i);
      #1;
      check("b2b_in_ready", bus.in_ready, 1);
      step();
      check("b2b_out_valid", bus.out_valid, 1);
      check("b2b_result", bus.result, 8'h10 + 8'(i));
    end
    bus.in_valid = 1'b0;
    step();
    check("b2b_drain", bus.out_valid, 0);

    // Reset during a shamt=7 shift
    bus.alu_opcode = LSL;
    bus.op_a       = 8'hFF;
    bus.op_b       = 8'h07;
    bus.in_valid   = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("mrst_in_ready_low", bus.in_ready, 0);
    step();
    check("mrst_out_valid", bus.out_valid, 0);
    check("mrst_result", bus.result, 0);
    check("mrst_flags", bus.flags, 0);
    rst_n = 1'b1;
    #1;
    check("mrst_idle", bus.in_ready, 1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.out_valid === 1'b1) n++;
    end
    check("mrst_no_late_result", n, 0);
    do_op("post_rst_sub", SUB, 8'h80, 8'h01, 0, 8'h7F, 4'b0011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
